// File: rtl/viterbi_codec.sv
// Rate-1/2, K=3 convolutional codec: (7,5) encoder plus a hard-decision
// Viterbi decoder with register-exchange survivors.
// Handshake: single-cycle strobes with no backpressure. The encoder consumes
// d_in on every rising edge where enable_i is high, and it raises valid_o for
// exactly one cycle per symbol produced. The decoder consumes d_in on every
// rising edge where enable is high. A consumer must take each symbol in the
// cycle where it is valid.

module encoder (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable_i,
  input  logic       d_in,
  output logic       valid_o,
  output logic [1:0] d_out
);

  // s[1] is the previous bit; s[0] is the bit before that.
  logic [1:0] s;

  // Produce a symbol from the current bit and the two previous bits, then shift.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s       <= 2'b00;
      d_out   <= 2'b00;
      valid_o <= 1'b0;
    end else if (enable_i) begin
      d_out   <= {d_in ^ s[1] ^ s[0], d_in ^ s[0]};
      valid_o <= 1'b1;
      s       <= {d_in, s[1]};
    end else begin
      valid_o <= 1'b0;
    end
  end

endmodule

module decoder #(
  parameter int L  = 16,
  parameter int MW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic [1:0]      d_in,
  output logic            d_out,
  output logic [4*MW-1:0] pm_dbg
);

  // Non-zero states start with a handicap, so that decoding begins from state 00.
  localparam logic [MW-1:0] PM_INIT = MW'(1 << (MW - 3));

  logic [MW-1:0] pm       [4];
  logic [L-1:0]  path     [4];
  logic [MW-1:0] acs_pm   [4];
  logic [L-1:0]  acs_path [4];
  logic [MW-1:0] min_pm;
  logic [1:0]    min_idx;

  function automatic logic [1:0] hamming(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] x;
    x = a ^ b;
    return {1'b0, x[1]} + {1'b0, x[0]};
  endfunction

  // Next state {b,a} is reached from {a,0} or from {a,1} on input bit b.
  // A tie keeps the predecessor whose s0 is 0.
  for (genvar g = 0; g < 4; g++) begin : g_acs
    localparam int B = g / 2;
    localparam int A = g % 2;
    localparam logic [1:0] P0 = 2'(2 * A);
    localparam logic [1:0] P1 = 2'(2 * A + 1);
    localparam logic [1:0] E0 = 2'((((B ^ A) & 1) << 1) | B);
    localparam logic [1:0] E1 = 2'((((B ^ A ^ 1) & 1) << 1) | (B ^ 1));

    logic [MW-1:0] cand0;
    logic [MW-1:0] cand1;
    logic          take1;

    assign cand0        = pm[P0] + MW'(hamming(d_in, E0));
    assign cand1        = pm[P1] + MW'(hamming(d_in, E1));
    assign take1        = cand1 < cand0;
    assign acs_pm[g]    = take1 ? cand1 : cand0;
    assign acs_path[g]  = {take1 ? path[P1][L-2:0] : path[P0][L-2:0], 1'(B)};
  end

  // Find the best new metric. A tie goes to the lowest state index.
  always_comb begin
    min_pm  = acs_pm[0];
    min_idx = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (acs_pm[i] < min_pm) begin
        min_pm  = acs_pm[i];
        min_idx = 2'(i);
      end
    end
  end

  // Commit the normalized metrics and the survivors. Emit the oldest bit of the best path.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pm[0] <= '0;
      pm[1] <= PM_INIT;
      pm[2] <= PM_INIT;
      pm[3] <= PM_INIT;
      for (int i = 0; i < 4; i++) path[i] <= '0;
      d_out <= 1'b0;
    end else if (enable) begin
      for (int i = 0; i < 4; i++) begin
        pm[i]   <= acs_pm[i] - min_pm;
        path[i] <= acs_path[i];
      end
      d_out <= acs_path[min_idx][L-1];
    end
  end

  assign pm_dbg = {pm[3], pm[2], pm[1], pm[0]};

endmodule

module viterbi_codec #(
  parameter int L  = 16,
  parameter int MW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enc_enable,
  input  logic            enc_d_in,
  output logic            enc_valid,
  output logic [1:0]      enc_d_out,
  input  logic            dec_enable,
  input  logic [1:0]      dec_d_in,
  output logic            dec_d_out,
  output logic [4*MW-1:0] dec_metrics
);

  encoder u_encoder (
    .clk      (clk),
    .rst      (rst),
    .enable_i (enc_enable),
    .d_in     (enc_d_in),
    .valid_o  (enc_valid),
    .d_out    (enc_d_out)
  );

  decoder #(.L(L), .MW(MW)) u_decoder (
    .clk    (clk),
    .rst    (rst),
    .enable (dec_enable),
    .d_in   (dec_d_in),
    .d_out  (dec_d_out),
    .pm_dbg (dec_metrics)
  );

endmodule

// File: tb/tb_viterbi_codec.sv
// Bench for viterbi_codec: encoder -> one-cycle register -> decoder loopback.
// A random bit stream is used, with error injection, enable gaps and a reset mid-stream.
module tb_viterbi_codec;

  localparam int L  = 16;
  localparam int MW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            enc_enable;
  logic            enc_d_in;
  logic            enc_valid;
  logic [1:0]      enc_d_out;
  logic            dec_enable;
  logic [1:0]      dec_d_in;
  logic            dec_d_out;
  logic [4*MW-1:0] dec_metrics;

  viterbi_codec #(.L(L), .MW(MW)) dut (
    .clk         (clk),
    .rst         (rst),
    .enc_enable  (enc_enable),
    .enc_d_in    (enc_d_in),
    .enc_valid   (enc_valid),
    .enc_d_out   (enc_d_out),
    .dec_enable  (dec_enable),
    .dec_d_in    (dec_d_in),
    .dec_d_out   (dec_d_out),
    .dec_metrics (dec_metrics)
  );

  // ---------------- loopback channel ----------------
  logic       stage_bit;
  logic       pipe_valid;
  logic [1:0] pipe_sym;
  logic       pipe_bit;
  logic       inject_on;
  logic       mon_on;
  int         acc = 0;
  bit         sent[$];

  // Carry the information bit alongside its symbol through the channel register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_bit  <= 1'b0;
      pipe_valid <= 1'b0;
      pipe_sym   <= 2'b00;
      pipe_bit   <= 1'b0;
    end else begin
      if (enc_enable) stage_bit <= enc_d_in;
      pipe_valid <= enc_valid;
      pipe_sym   <= enc_d_out;
      pipe_bit   <= stage_bit;
    end
  end

  assign dec_enable = pipe_valid;
  assign dec_d_in   = pipe_sym ^ {1'b0, inject_on && pipe_valid && (acc % 16 == 8)};

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Encoder reference: each symbol is a parity over the last three information bits.
  initial begin
    logic     snap_en, snap_d, p1, p2, exp_v;
    logic [1:0] exp_sym;
    bit       hist[$];
    snap_en = 1'b0; snap_d = 1'b0; exp_v = 1'b0; exp_sym = 2'b00;
    forever begin
      @(negedge clk);
      if (!rst) begin
        hist.delete();
        snap_en = 1'b0; exp_v = 1'b0; exp_sym = 2'b00;
      end else begin
        snap_en = enc_enable;
        snap_d  = enc_d_in;
      end
      @(posedge clk); #1;
      if (rst) begin
        if (snap_en) begin
          p1 = (hist.size() >= 1) ? hist[hist.size()-1] : 1'b0;
          p2 = (hist.size() >= 2) ? hist[hist.size()-2] : 1'b0;
          exp_sym = {snap_d ^ p1 ^ p2, snap_d ^ p2};
          exp_v   = 1'b1;
          hist.push_back(snap_d);
        end else begin
          exp_v = 1'b0;
        end
      end
      if (mon_on) begin
        check("enc_valid", enc_valid, exp_v);
        check("enc_d_out", enc_d_out, exp_sym);
      end
    end
  end

  // Decoder reference: after the n-th accepted symbol, d_out is the info bit of symbol n-L.
  initial begin
    logic          snap_en, snap_bit, exp_out;
    logic [MW-1:0] pmin, f;
    snap_en = 1'b0; snap_bit = 1'b0; exp_out = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        sent.delete();
        acc = 0; exp_out = 1'b0; snap_en = 1'b0;
      end else begin
        snap_en  = dec_enable;
        snap_bit = pipe_bit;
      end
      @(posedge clk); #1;
      if (rst && snap_en) begin
        sent.push_back(snap_bit);
        acc++;
        exp_out = (acc >= L) ? sent[acc-L] : 1'b0;
      end
      pmin = dec_metrics[MW-1:0];
      for (int i = 1; i < 4; i++) begin
        f = dec_metrics[i*MW +: MW];
        if (f < pmin) pmin = f;
      end
      if (mon_on) begin
        check("dec_d_out", dec_d_out, exp_out);
        check("pm_min", pmin, 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic send_bits(input int n);
    for (int i = 0; i < n; i++) begin
      enc_enable = 1'b1;
      enc_d_in   = 1'($urandom_range(0, 1));
      tick();
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_enc_d_out"}, enc_d_out, 2'b00);
    check({tag, "_enc_valid"}, enc_valid, 1'b0);
    check({tag, "_dec_d_out"}, dec_d_out, 1'b0);
    check({tag, "_metrics"}, dec_metrics, 32'h2020_2000);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic       vin  [4];
    logic [1:0] vexp [4];
    vin  = '{1'b1, 1'b0, 1'b1, 1'b1};
    vexp = '{2'b11, 2'b10, 2'b00, 2'b01};
    enc_enable = 1'b0; enc_d_in = 1'b0; inject_on = 1'b0; mon_on = 1'b0;

    #3 rst = 1'b0;
    mon_on = 1'b1;
    #1 check_reset_values("reset");
    tick();
    tick();
    rst = 1'b1;

    // Known encoder vector, starting from reset.
    for (int i = 0; i < 4; i++) begin
      enc_enable = 1'b1;
      enc_d_in   = vin[i];
      @(posedge clk); #1;
      check("vec_sym", enc_d_out, vexp[i]);
      check("vec_valid", enc_valid, 1'b1);
      #1;
    end

    // Clean loopback.
    send_bits(256);

    // Enable gap: the encoder and then the decoder pause for 5 cycles.
    for (int i = 0; i < 5; i++) begin
      enc_enable = 1'b0;
      enc_d_in   = 1'($urandom_range(0, 1));
      tick();
    end
    send_bits(64);

    // Reset pulse in the middle of traffic.
    rst = 1'b0;
    #1 check_reset_values("midrst");
    tick();
    rst = 1'b1;

    // New stream with one flipped bit every 16 symbols.
    inject_on = 1'b1;
    send_bits(256);
    enc_enable = 1'b0;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Bound the run.
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/viterbi_codec.md
VITERBI_CODEC -- requirements
Module: viterbi_codec (implemented as two submodules: encoder, decoder)

Interface
REQ-001 Reset is rst, asynchronous, active-low; clock is clk; both submodules use clk and rst.
REQ-002 Parameter L, default 16: survivor path length (decision depth) of the decoder, in symbols.
REQ-003 Parameter MW, default 8: path-metric width in bits.
REQ-004 encoder: clk  in  1  rising-edge clock.
REQ-005 encoder: rst  in  1  async active-low reset.
REQ-006 encoder: enable_i  in  1  high means sample d_in this edge.
REQ-007 encoder: d_in  in  1  information bit.
REQ-008 encoder: valid_o  out  1  high means d_out holds a fresh symbol.
REQ-009 encoder: d_out  out  2  encoded symbol {g0,g1}.
REQ-010 decoder: clk  in  1  rising-edge clock.
REQ-011 decoder: rst  in  1  async active-low reset.
REQ-012 decoder: enable  in  1  high means d_in is a valid received symbol this edge.
REQ-013 decoder: d_in  in  2  received hard-decision symbol {g0,g1}, possibly corrupted.
REQ-014 decoder: d_out  out  1  decoded information bit.

Function
REQ-015 Code: rate 1/2, constraint length K=3, generators g0=111 (octal 7), g1=101 (octal 5); state s={s1,s0}, s1 = previous bit, s0 = bit before that.
REQ-016 Encoder: on an edge with enable_i=1, d_out <= {d_in^s1^s0, d_in^s0}, valid_o <= 1, then {s1,s0} <= {d_in,s1}; latency 1 cycle.
REQ-017 Encoder: on an edge with enable_i=0, valid_o <= 0; d_out and state hold.
REQ-018 Decoder trellis: 4 states; next state {b,a} has predecessors {a,0} and {a,1} with input bit b; the expected symbol from predecessor {a,c} is {b^a^c, b^c}.
REQ-019 Branch metric = Hamming distance (0..2) between d_in and the expected symbol.
REQ-020 ACS per state on each enabled edge: candidate = PM[pred] + BM; the smaller candidate is kept; ties select the predecessor with s0=0.
REQ-021 Survivors use register exchange: new_path[ns] = {path[selected pred][L-2:0], b}; bit 0 is the newest, bit L-1 the oldest.
REQ-022 Metric normalization: after ACS, subtract the minimum of the 4 new metrics from all 4; metrics are unsigned MW bits and never overflow.
REQ-023 Output: on each enabled edge, d_out <= bit L-1 of the new survivor of the state with the minimum new metric (ties go to the lowest state index).
REQ-024 Decision latency: a symbol accepted at enabled edge k determines d_out at enabled edge k+L-1 (16 enabled edges inclusive for L=16).
REQ-025 Decoder with enable=0: metrics, survivors and d_out hold unchanged.
REQ-026 Correction capability: free distance 5; any pattern of one flipped bit per 16 consecutive symbols decodes error-free.

Reset
REQ-027 On rst=0 (any time, asynchronously): encoder state=00, d_out=00, valid_o=0; decoder PM[0]=0, PM[1..3]=2**(MW-3) (32 for MW=8); all survivors=0; d_out=0.
REQ-028 Operation resumes on the first rising edge after rst returns high; a reset mid-stream discards all trellis history.

Verification
REQ-029 Reset: assert rst=0 -> encoder d_out=00, valid_o=0; decoder d_out=0; metrics {0,32,32,32}.
REQ-030 Encoder vector: from reset, enable_i=1, d_in=1,0,1,1 -> d_out=11,10,00,01 on successive edges, valid_o=1.
REQ-031 Clean loopback: encoder -> 1-cycle register (symbol and valid) -> decoder enable, 256 random bits -> decoder d_out equals encoder d_in delayed 17 clocks, 0 bit errors.
REQ-032 Injected errors: same chain, flip d_in[0] of the decoder once every 16 symbols for 256 symbols -> 0 decoded bit errors.
REQ-033 Enable gaps: deassert enable_i/enable for 5 cycles mid-stream -> outputs hold; the decoded stream is unchanged apart from the pause.
REQ-034 Mid-stream reset: pulse rst low for 1 cycle during traffic -> all reset values restored immediately; the new stream decodes error-free with the REQ-031 latency.
